// File: rtl/instruction_fetch.sv
// PC generation and fetch stage: issues word-indexed reads to ProgramMemory,
// absorbs its 1-cycle read latency and presents the IF/ID pipeline register.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        JUMP,
  input  logic [25:0] JUMP_INDEX,
  output logic        IMEM_READ,
  output logic        IMEM_WRITE,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PC_PLUS4,
  output logic        IF_VALID,
  output logic        FETCH_FAULT
);

  localparam logic [0:0]  RUN   = 1'b0;
  localparam logic [0:0]  FAULT = 1'b1;
  localparam logic [31:0] WORDS = 32'(IMEM_WORDS);

  logic [0:0]  state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        req_valid;
  logic        at_end;
  logic [31:0] seq_pc;
  logic [31:0] jump_target;
  logic        reset_pc_bad;
  logic        branch_bad;
  logic        jump_bad;
  logic        seq_bad;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= WORDS);
  endfunction

  always_comb begin
    seq_pc       = pc + 32'd4;
    jump_target  = {IF_PC_PLUS4[31:28], JUMP_INDEX, 2'b00};
    reset_pc_bad = bad_addr(RESET_PC);
    branch_bad   = bad_addr(BRANCH_TARGET);
    jump_bad     = bad_addr(jump_target);
    seq_bad      = bad_addr(seq_pc);
  end

  // During a stall the memory re-reads the held request so its data is
  // still current on the release cycle.
  always_comb begin
    IMEM_READ  = (state == RUN);
    IMEM_WRITE = 1'b0;
    IMEM_ADDR  = STALL ? (req_pc >> 2) : (pc >> 2);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc          <= reset_pc_bad ? '0 : RESET_PC;
      req_pc      <= '0;
      req_valid   <= 1'b0;
      at_end      <= 1'b0;
      IF_INSTR    <= '0;
      IF_PC       <= '0;
      IF_PC_PLUS4 <= '0;
      IF_VALID    <= 1'b0;
      FETCH_FAULT <= reset_pc_bad;
      state       <= reset_pc_bad ? FAULT : RUN;
    end else if (state == RUN) begin
      if (BRANCH_TAKEN) begin
        if (branch_bad) begin
          state       <= FAULT;
          FETCH_FAULT <= 1'b1;
          req_valid   <= 1'b0;
          IF_VALID    <= 1'b0;
        end else begin
          pc        <= BRANCH_TARGET;
          req_valid <= 1'b0;
          IF_VALID  <= 1'b0;
          at_end    <= 1'b0;
        end
      end else if (JUMP && IF_VALID) begin
        if (jump_bad) begin
          state       <= FAULT;
          FETCH_FAULT <= 1'b1;
          req_valid   <= 1'b0;
          IF_VALID    <= 1'b0;
        end else begin
          pc        <= jump_target;
          req_valid <= 1'b0;
          IF_VALID  <= 1'b0;
          at_end    <= 1'b0;
        end
      end else if (!STALL) begin
        // Falling off the last word: pc is held, the in-flight last word
        // drains into IF/ID first, and the fault is raised on the edge after.
        if (at_end) begin
          if (req_valid) begin
            IF_INSTR    <= IMEM_DATA;
            IF_PC       <= req_pc;
            IF_PC_PLUS4 <= req_pc + 32'd4;
            IF_VALID    <= 1'b1;
            req_valid   <= 1'b0;
          end else begin
            state       <= FAULT;
            FETCH_FAULT <= 1'b1;
            IF_VALID    <= 1'b0;
          end
        end else begin
          IF_INSTR    <= IMEM_DATA;
          IF_PC       <= req_pc;
          IF_PC_PLUS4 <= req_pc + 32'd4;
          IF_VALID    <= req_valid;
          req_pc      <= pc;
          req_valid   <= 1'b1;
          if (seq_bad) begin
            at_end <= 1'b1;
          end else begin
            pc <= seq_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: vector table for the main flow plus
// hand sequences for end-of-memory, misaligned/out-of-range faults and reset.
module tb_instruction_fetch;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TARGET;
  logic        JUMP;
  logic [25:0] JUMP_INDEX;
  logic        IMEM_READ;
  logic        IMEM_WRITE;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;
  logic [31:0] IF_PC_PLUS4;
  logic        IF_VALID;
  logic        FETCH_FAULT;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(32)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .STALL        (STALL),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET),
    .JUMP         (JUMP),
    .JUMP_INDEX   (JUMP_INDEX),
    .IMEM_READ    (IMEM_READ),
    .IMEM_WRITE   (IMEM_WRITE),
    .IMEM_ADDR    (IMEM_ADDR),
    .IMEM_DATA    (IMEM_DATA),
    .IF_INSTR     (IF_INSTR),
    .IF_PC        (IF_PC),
    .IF_PC_PLUS4  (IF_PC_PLUS4),
    .IF_VALID     (IF_VALID),
    .FETCH_FAULT  (FETCH_FAULT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ProgramMemory model: word k holds k+100, registered read.
  always @(posedge CLK) begin
    if (IMEM_READ) begin
      if (IMEM_ADDR < 32) IMEM_DATA <= IMEM_ADDR + 32'd100;
      else                IMEM_DATA <= 32'hDEAD_BEEF;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic j, input logic [25:0] ji,
                              input logic [31:0] a, input logic v,
                              input logic [31:0] p, input logic [31:0] ins);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.jmp = j; r.jidx = ji;
    r.exp_addr = a; r.exp_valid = v; r.exp_pc = p; r.exp_instr = ins;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic s, input logic b, input logic [31:0] t,
                       input logic j, input logic [25:0] ji);
    RESET = rst; STALL = s; BRANCH_TAKEN = b; BRANCH_TARGET = t; JUMP = j; JUMP_INDEX = ji;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    chk("imem_write", {31'b0, IMEM_WRITE}, 32'd0);
  endtask

  task automatic chk_if(input string tag, input logic [31:0] p, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'b0, IF_VALID}, 32'd1);
    chk({tag, "_pc"}, IF_PC, p);
    chk({tag, "_pc4"}, IF_PC_PLUS4, p + 32'd4);
    chk({tag, "_instr"}, IF_INSTR, ins);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_instr"}, IF_INSTR, 32'd0);
    chk({tag, "_pc"}, IF_PC, 32'd0);
    chk({tag, "_pc4"}, IF_PC_PLUS4, 32'd0);
    chk({tag, "_valid"}, {31'b0, IF_VALID}, 32'd0);
    chk({tag, "_fault"}, {31'b0, FETCH_FAULT}, 32'd0);
  endtask

  task automatic chk_faulted(input string tag);
    chk({tag, "_fault"}, {31'b0, FETCH_FAULT}, 32'd1);
    chk({tag, "_valid"}, {31'b0, IF_VALID}, 32'd0);
    chk({tag, "_read"}, {31'b0, IMEM_READ}, 32'd0);
  endtask

  // Reset, then two free-running edges; the second shows word 0.
  task automatic restart(input string tag);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    chk_zero({tag, "_rst"});
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk({tag, "_bubble"}, {31'b0, IF_VALID}, 32'd0);
    tick();
    chk_if({tag, "_first"}, 32'h0, 32'd100);
  endtask

  initial begin
    vecs[0]  = mk(0, 0, 0,     0, 0, 0,  0, 0,     0);
    vecs[1]  = mk(0, 0, 0,     0, 0, 1,  1, 0,     100);
    vecs[2]  = mk(0, 0, 0,     0, 0, 2,  1, 4,     101);
    vecs[3]  = mk(0, 0, 0,     0, 0, 3,  1, 8,     102);
    vecs[4]  = mk(1, 0, 0,     0, 0, 3,  1, 8,     102);
    vecs[5]  = mk(1, 0, 0,     0, 0, 3,  1, 8,     102);
    vecs[6]  = mk(1, 0, 0,     0, 0, 3,  1, 8,     102);
    vecs[7]  = mk(0, 0, 0,     0, 0, 4,  1, 12,    103);
    vecs[8]  = mk(0, 0, 0,     0, 0, 5,  1, 16,    104);
    vecs[9]  = mk(1, 1, 32'h40, 1, 5, 5,  0, 0,     0);
    vecs[10] = mk(0, 0, 0,     0, 0, 16, 0, 0,     0);
    vecs[11] = mk(0, 0, 0,     0, 0, 17, 1, 32'h40, 116);
    vecs[12] = mk(0, 0, 0,     0, 0, 18, 1, 32'h44, 117);
    vecs[13] = mk(0, 0, 0,     1, 5, 19, 0, 0,     0);
    vecs[14] = mk(0, 0, 0,     1, 9, 5,  0, 0,     0);
    vecs[15] = mk(0, 0, 0,     0, 0, 6,  1, 32'h14, 105);
    vecs[16] = mk(0, 0, 0,     0, 0, 7,  1, 32'h18, 106);

    drive(1, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk_zero("reset");
    chk("reset_read", {31'b0, IMEM_READ}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      drive(0, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].jmp, vecs[i].jidx);
      #1;
      chk($sformatf("v%0d_addr", i), IMEM_ADDR, vecs[i].exp_addr);
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, IF_VALID}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), IF_PC, vecs[i].exp_pc);
        chk($sformatf("v%0d_pc4", i), IF_PC_PLUS4, vecs[i].exp_pc + 32'd4);
        chk($sformatf("v%0d_instr", i), IF_INSTR, vecs[i].exp_instr);
      end
    end

    // Sequential run through the last word, then fall-through fault.
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 7; k < 32; k++) begin
      tick();
      chk_if($sformatf("seq%0d", k), 32'(k) * 32'd4, 32'(k) + 32'd100);
      chk($sformatf("seq%0d_fault", k), {31'b0, FETCH_FAULT}, 32'd0);
    end
    tick();
    chk_faulted("end");
    drive(0, 0, 1, 32'h0, 1, 1);
    tick();
    chk_faulted("end_ignore");

    // Misaligned branch target.
    restart("mis");
    drive(0, 0, 1, 32'h42, 0, 0);
    tick();
    chk_faulted("mis");
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_faulted("mis_hold");

    // Branch target one word past the end of memory.
    restart("oor");
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_if("oor_run", 32'h4, 32'd101);
    drive(0, 0, 1, 32'h80, 0, 0);
    tick();
    chk_faulted("oor");
    tick();
    chk_faulted("oor_hold");

    // Reset asserted in the middle of a stall.
    restart("rs");
    drive(0, 1, 0, 0, 0, 0);
    tick();
    chk_if("rs_stall", 32'h0, 32'd100);
    drive(1, 1, 0, 0, 0, 0);
    tick();
    chk_zero("rs_clear");
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk_if("rs_restart", 32'h0, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
